// File: rtl/pwm_led_pkg.sv
// Shared definitions for the multi-channel PWM LED driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   mode_t     - 2-bit per-channel operating mode
//   MODE_*     - encodings: off, fixed duty, breathing, anti-phase breathing
//   min_width  - clamps a derived bus width to at least one bit
package pwm_led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'b00;
  localparam mode_t MODE_FIXED  = 2'b01;
  localparam mode_t MODE_BREATH = 2'b10;
  localparam mode_t MODE_ANTI   = 2'b11;

  // $clog2(1) is 0; a port still needs one bit.
  function automatic int min_width(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pwm_ramp_gen.sv
// Shared timebase: prescaler, PWM frame counter and triangular brightness ramp.
// Latency: counters are registered; frame_end is combinational from them.
// Backpressure: none, free-running from reset release.
//
// Ports:
//   sys_clk, sys_rst - clock, synchronous active-high reset
//   pwm_cnt          - PWM step within the frame, 0..LEVELS-1
//   lvl              - brightness level for the current frame, 0..LEVELS
//   frame_end        - high on the last cycle of each frame
//   ramp_up          - ramp direction, 1 = rising
module pwm_ramp_gen #(
  parameter int CNT_TICK = 100,
  parameter int LEVELS   = 1000,
  parameter int DW       = $clog2(LEVELS + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  output logic [DW-1:0] pwm_cnt,
  output logic [DW-1:0] lvl,
  output logic          frame_end,
  output logic          ramp_up
);

  // With CNT_TICK=1 the prescaler is a single bit pinned at 0, so tick is
  // permanently high and pwm_cnt advances every cycle.
  localparam int PW = (CNT_TICK > 1) ? $clog2(CNT_TICK) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick      = (pre_cnt == PW'(CNT_TICK - 1));
  assign frame_end = tick && (pwm_cnt == DW'(LEVELS - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      lvl     <= '0;
      ramp_up <= 1'b1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);

      if (tick) begin
        pwm_cnt <= (pwm_cnt == DW'(LEVELS - 1)) ? '0 : pwm_cnt + DW'(1);
      end

      // The level only moves between frames so every channel sees one
      // constant brightness for the whole frame. At either extreme the
      // direction turns and the level steps away in the same update, so each
      // extreme is held for exactly one frame.
      if (frame_end) begin
        if (ramp_up) begin
          if (lvl == DW'(LEVELS)) begin
            ramp_up <= 1'b0;
            lvl     <= DW'(LEVELS - 1);
          end else begin
            lvl <= lvl + DW'(1);
          end
        end else begin
          if (lvl == '0) begin
            ramp_up <= 1'b1;
            lvl     <= DW'(1);
          end else begin
            lvl <= lvl - DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pwm_led_multi.sv
// Multi-channel PWM LED driver with per-channel off/fixed/breath/anti-phase modes.
// Latency: led is registered one cycle behind the compare; config applies from the next frame.
// Backpressure: none, every config write is accepted in the cycle it is strobed.
//
// Ports:
//   sys_clk, sys_rst - clock, synchronous active-high reset
//   cfg_we           - write strobe for one channel's {mode, duty}
//   cfg_ch           - target channel; values >= CH_NUM are ignored
//   cfg_mode         - 00 off, 01 fixed, 10 breath, 11 anti-phase breath
//   cfg_duty         - fixed-mode duty, clamped to LEVELS on write
//   led              - PWM outputs, polarity set by LED_ACT_HIGH
//   frame_start      - one-cycle pulse on the first cycle of each frame
//   ramp_up          - ramp direction (1 = rising)
module pwm_led_multi #(
  parameter int  CH_NUM       = 4,
  parameter int  CNT_TICK     = 100,
  parameter int  LEVELS       = 1000,
  parameter int  LED_ACT_HIGH = 1,
  localparam int DW           = $clog2(LEVELS + 1),
  localparam int CW           = pwm_led_pkg::min_width($clog2(CH_NUM))
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DW-1:0]     cfg_duty,
  output logic [CH_NUM-1:0] led,
  output logic              frame_start,
  output logic              ramp_up
);

  import pwm_led_pkg::*;

  localparam logic INV = (LED_ACT_HIGH == 0);

  logic [DW-1:0]     pwm_cnt;
  logic [DW-1:0]     lvl;
  logic              frame_end;
  logic [DW-1:0]     wr_duty;
  logic [CH_NUM-1:0] lit;

  pwm_ramp_gen #(
    .CNT_TICK (CNT_TICK),
    .LEVELS   (LEVELS),
    .DW       (DW)
  ) u_ramp (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pwm_cnt   (pwm_cnt),
    .lvl       (lvl),
    .frame_end (frame_end),
    .ramp_up   (ramp_up)
  );

  // Clamping at write time keeps the stored duty within 0..LEVELS.
  assign wr_duty = (cfg_duty > DW'(LEVELS)) ? DW'(LEVELS) : cfg_duty;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    mode_t         sh_mode;
    mode_t         act_mode;
    logic [DW-1:0] sh_duty;
    logic [DW-1:0] act_duty;
    logic [DW-1:0] eff_duty;
    logic          wr_hit;

    // Only channel indices below CH_NUM exist, so an out-of-range cfg_ch
    // matches no channel and the write falls away.
    assign wr_hit = cfg_we && (cfg_ch == CW'(i));

    // Shadow collects writes during the frame; active only changes at the
    // frame boundary so a channel's duty never changes mid-frame. A write on
    // the boundary cycle itself bypasses the shadow so it is not lost a frame.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sh_mode  <= MODE_OFF;
        sh_duty  <= '0;
        act_mode <= MODE_OFF;
        act_duty <= '0;
      end else begin
        if (wr_hit) begin
          sh_mode <= mode_t'(cfg_mode);
          sh_duty <= wr_duty;
        end
        if (frame_end) begin
          if (wr_hit) begin
            act_mode <= mode_t'(cfg_mode);
            act_duty <= wr_duty;
          end else begin
            act_mode <= sh_mode;
            act_duty <= sh_duty;
          end
        end
      end
    end

    always_comb begin
      eff_duty = '0;
      case (act_mode)
        MODE_OFF:    eff_duty = '0;
        MODE_FIXED:  eff_duty = act_duty;
        MODE_BREATH: eff_duty = lvl;
        MODE_ANTI:   eff_duty = DW'(LEVELS) - lvl;
        default:     eff_duty = '0;
      endcase
    end

    // Strict compare: duty 0 never lights, duty LEVELS lights every step.
    assign lit[i] = (pwm_cnt < eff_duty);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led         <= {CH_NUM{INV}};
      frame_start <= 1'b0;
    end else begin
      led         <= lit ^ {CH_NUM{INV}};
      frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_pwm_led_multi.sv
module tb_pwm_led_multi;
  import pwm_led_pkg::*;

  localparam int CH = 2;
  localparam int T  = 2;
  localparam int L  = 4;
  localparam int FR = T * L;
  localparam int DW = $clog2(L + 1);

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          cfg_we;
  logic [0:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_duty;
  logic [CH-1:0] led;
  logic          frame_start;
  logic          ramp_up;

  logic          d1_we;
  logic [0:0]    d1_ch;
  logic [1:0]    d1_mode;
  logic [DW-1:0] d1_duty;
  logic [0:0]    d1_led;
  logic          d1_fs;
  logic          d1_ramp;

  always #5 sys_clk = ~sys_clk;

  pwm_led_multi #(.CH_NUM(CH), .CNT_TICK(T), .LEVELS(L), .LED_ACT_HIGH(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .led(led),
    .frame_start(frame_start), .ramp_up(ramp_up)
  );

  pwm_led_multi #(.CH_NUM(1), .CNT_TICK(T), .LEVELS(L), .LED_ACT_HIGH(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_we(d1_we), .cfg_ch(d1_ch),
    .cfg_mode(d1_mode), .cfg_duty(d1_duty), .led(d1_led),
    .frame_start(d1_fs), .ramp_up(d1_ramp)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: k = cycles since last reset edge.
  int            k = 0;
  int            cur_m[CH];
  int            cur_d[CH];
  int            frm_m[CH];
  int            frm_d[CH];
  logic [CH-1:0] prev_lit = '0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Triangle: frame f brightness rises 0..L then falls back, period 2L frames.
  function automatic int lvl_of(input int f);
    int p;
    p = f % (2 * L);
    return (p <= L) ? p : 2 * L - p;
  endfunction

  // Direction is rising for the very first frame and for frames 1..L of each
  // period afterwards (the bottom frame of later periods is still falling).
  function automatic logic ramp_of(input int f);
    int p;
    p = f % (2 * L);
    return (f == 0) || (p >= 1 && p <= L);
  endfunction

  function automatic int eff(input int m, input int d, input int f);
    case (m)
      0:       return 0;
      1:       return d;
      2:       return lvl_of(f);
      default: return L - lvl_of(f);
    endcase
  endfunction

  // Check the current cycle against the model, drive inputs for it, advance.
  task automatic cyc(input logic rst, input logic we, input int ch, input int mode, input int duty);
    int            f;
    int            pwm;
    logic [CH-1:0] lit;
    logic [CH+1:0] exp_v;
    logic [CH+1:0] act_v;
    f   = k / FR;
    pwm = (k % FR) / T;
    if (k % FR == 0) begin
      for (int c = 0; c < CH; c++) begin
        frm_m[c] = cur_m[c];
        frm_d[c] = cur_d[c];
      end
    end
    for (int c = 0; c < CH; c++) lit[c] = (pwm < eff(frm_m[c], frm_d[c], f));
    exp_v = {prev_lit, (k > 0 && k % FR == 0), ramp_of(f)};
    act_v = {led, frame_start, ramp_up};
    check($sformatf("cycle k=%0d {led,frame_start,ramp_up}", k), int'(act_v), int'(exp_v));
    prev_lit = lit;

    sys_rst  = rst;
    cfg_we   = we;
    cfg_ch   = ch[0:0];
    cfg_mode = mode[1:0];
    cfg_duty = duty[DW-1:0];
    if (rst) begin
      k        = 0;
      prev_lit = '0;
      for (int c = 0; c < CH; c++) begin
        cur_m[c] = 0;
        cur_d[c] = 0;
      end
    end else begin
      if (we && ch < CH) begin
        cur_m[ch] = mode;
        cur_d[ch] = (duty > L) ? L : duty;
      end
      k++;
    end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Count lit cycles over one frame starting at k%FR==1 (the frame just begun).
  task automatic count_frame(output int h0, output int h1, output int f);
    while (k % FR != 1) idle();
    f  = (k - 1) / FR;
    h0 = 0;
    h1 = 0;
    for (int j = 0; j < FR; j++) begin
      h0 += int'(led[0]);
      h1 += int'(led[1]);
      idle();
    end
  endtask

  typedef struct {
    int m0; int d0; int m1; int d1; int hi0; int hi1;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int h0, h1, f, fs_n, d1_a, d1_b;

    tbl[0] = '{1, 2, 0, 0, 4, 0};
    tbl[1] = '{1, 0, 1, 4, 0, 8};
    tbl[2] = '{1, 7, 1, 1, 8, 2};
    tbl[3] = '{0, 3, 1, 3, 0, 6};
    tbl[4] = '{1, 4, 1, 2, 8, 4};
    tbl[5] = '{1, 5, 1, 3, 8, 6};
    tbl[6] = '{0, 0, 0, 0, 0, 0};

    for (int c = 0; c < CH; c++) begin
      cur_m[c] = 0; cur_d[c] = 0; frm_m[c] = 0; frm_d[c] = 0;
    end
    sys_rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_duty = '0;
    d1_we = 1'b0; d1_ch = '0; d1_mode = '0; d1_duty = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset led", int'(led), 0);
    check("reset frame_start", int'(frame_start), 0);
    check("reset ramp_up", int'(ramp_up), 1);
    check("reset led (CH_NUM=1)", int'(d1_led), 0);

    // Idle 200 cycles; the single-channel build sees an out-of-range write
    // and then an over-range duty.
    fs_n = 0; d1_a = 0; d1_b = 0;
    for (int i = 0; i < 200; i++) begin
      d1_we   = (k == 3 || k == 18);
      d1_ch   = (k == 3) ? 1'b1 : 1'b0;
      d1_mode = MODE_FIXED;
      d1_duty = (k == 3) ? DW'(4) : DW'(7);
      if (k >= 9 && k <= 16)  d1_a += int'(d1_led);
      if (k >= 25 && k <= 32) d1_b += int'(d1_led);
      if (frame_start) fs_n++;
      idle();
    end
    d1_we = 1'b0;
    check("frame_start pulses in 200 idle cycles", fs_n, 24);
    check("CH_NUM=1 out-of-range write ignored", d1_a, 0);
    check("CH_NUM=1 duty 7 clamped, fully lit", d1_b, FR);

    // Fixed/off table: writes land in one frame, counted in the next.
    for (int e = 0; e < 7; e++) begin
      while (k % FR != 0) idle();
      cyc(1'b0, 1'b1, 0, tbl[e].m0, tbl[e].d0);
      cyc(1'b0, 1'b1, 1, tbl[e].m1, tbl[e].d1);
      count_frame(h0, h1, f);
      check($sformatf("table %0d ch0 high cycles", e), h0, tbl[e].hi0);
      check($sformatf("table %0d ch1 high cycles", e), h1, tbl[e].hi1);
    end

    // Breath on ch0, anti-phase on ch1.
    while (k % FR != 0) idle();
    cyc(1'b0, 1'b1, 0, 2, 0);
    cyc(1'b0, 1'b1, 1, 3, 0);
    for (int n = 0; n < 10; n++) begin
      count_frame(h0, h1, f);
      check($sformatf("breath frame %0d ch0", f), h0, T * lvl_of(f));
      check($sformatf("anti frame %0d ch0+ch1", f), h0 + h1, T * L);
    end

    // Two writes in one frame: last wins.
    while (k % FR != 2) idle();
    cyc(1'b0, 1'b1, 0, 1, 1);
    idle();
    cyc(1'b0, 1'b1, 0, 1, 3);
    count_frame(h0, h1, f);
    check("last write wins ch0", h0, 6);

    // Write on the frame_end cycle applies to the very next frame.
    while (k % FR != FR - 1) idle();
    cyc(1'b0, 1'b1, 0, 1, 1);
    count_frame(h0, h1, f);
    check("frame_end write bypass ch0", h0, 2);

    // Mid-frame reset with ch0 breathing.
    cyc(1'b0, 1'b1, 0, 2, 0);
    repeat (3 * FR) idle();
    while (k % FR != 3) idle();
    cyc(1'b1, 1'b0, 0, 0, 0);
    check("post-reset led", int'(led), 0);
    check("post-reset ramp_up", int'(ramp_up), 1);
    check("post-reset frame_start", int'(frame_start), 0);
    h1 = 0;
    for (int n = 0; n < 3; n++) begin
      count_frame(h0, f, f);
      h1 += h0;
    end
    check("breath stays off after reset", h1, 0);
    cyc(1'b0, 1'b1, 0, 2, 0);
    repeat (3 * FR) idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) cyc(1'b1, 1'b0, 0, 0, 0);
      else if (r < 150)
        cyc(1'b0, 1'b1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7));
      else idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
